// File: rtl/mul_step_counter.sv
`default_nettype none
// ============================================================================
// Module   : mul_step_counter
// Brief    : Step sequencer for the shift-add multiplier; walks the operandB
//            bit index 0..limit with hold, early stop and abort.
// Revision : 1.0 - initial release
// ============================================================================
module mul_step_counter #(
    parameter int OPERAND_WIDTH = 4,
    parameter int CNT_WIDTH     = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [CNT_WIDTH-1:0] limit,
    input  logic                 hold,
    input  logic                 early_stop,
    input  logic                 abort,
    output logic [CNT_WIDTH-1:0] count,
    output logic                 step_en,
    output logic                 last,
    output logic                 busy,
    output logic                 done
);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_run  = 2'd1;
    localparam logic [1:0] c_st_done = 2'd2;

    localparam logic [CNT_WIDTH-1:0] c_max_step = CNT_WIDTH'(OPERAND_WIDTH - 1);

    if ((2 ** CNT_WIDTH) < OPERAND_WIDTH) begin : g_width_check
        $error("mul_step_counter: CNT_WIDTH too small for OPERAND_WIDTH");
    end

    logic [1:0]           r_state;
    logic [1:0]           w_state_next;
    logic [CNT_WIDTH-1:0] r_count;
    logic [CNT_WIDTH-1:0] r_limit_q;
    logic                 r_busy;
    logic                 r_done;
    logic [CNT_WIDTH:0]   w_inc;
    logic [CNT_WIDTH-1:0] w_limit_clamp;
    logic                 w_at_limit;

    assign w_inc         = {1'b0, r_count} + {{CNT_WIDTH{1'b0}}, 1'b1};
    assign w_limit_clamp = (limit > c_max_step) ? c_max_step : limit;
    assign w_at_limit    = (r_count == r_limit_q);

    // State register plus the count/limit datapath it controls
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= c_st_idle;
            r_count   <= '0;
            r_limit_q <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_busy  <= (w_state_next != c_st_idle);
            r_done  <= (w_state_next == c_st_done);
            case (r_state)
                c_st_idle: begin
                    if (start) begin
                        r_limit_q <= w_limit_clamp;
                        r_count   <= '0;
                    end
                end
                c_st_run: begin
                    if (abort) begin
                        r_count <= '0;
                    end else if (!hold && !w_at_limit && !early_stop) begin
                        r_count <= w_inc[CNT_WIDTH-1:0];
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_st_idle: begin
                if (start) begin
                    w_state_next = c_st_run;
                end
            end
            c_st_run: begin
                if (abort) begin
                    w_state_next = c_st_idle;
                end else if (hold) begin
                    w_state_next = c_st_run;
                end else if (w_at_limit || early_stop) begin
                    w_state_next = c_st_done;
                end
            end
            c_st_done: w_state_next = c_st_idle;
            default:   w_state_next = c_st_idle;
        endcase
    end

    always_comb begin
        step_en = (r_state == c_st_run) && !hold && !abort;
        last    = (r_state == c_st_run) && w_at_limit;
    end

    assign count = r_count;
    assign busy  = r_busy;
    assign done  = r_done;

    // The count is bounded by limit_q, so an increment must never carry out
    always_ff @(posedge clk) begin
        if (!reset && step_en && !w_at_limit && !early_stop) begin
            assert (!w_inc[CNT_WIDTH])
            else $error("mul_step_counter: step counter overflow");
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mul_step_counter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mul_step_counter
// Brief    : Randomised scoreboard bench for mul_step_counter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mul_step_counter;

    localparam int OW = 6;
    localparam int CW = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [CW-1:0] limit;
    logic          hold;
    logic          early_stop;
    logic          abort;
    logic [CW-1:0] count;
    logic          step_en;
    logic          last;
    logic          busy;
    logic          done;

    int n_checks = 0;
    int n_errors = 0;
    int n_stray  = 0;

    typedef struct {
        bit done;
        int busy_cycles;
        int steps;
        int lasts;
        int step_sum;
        int final_count;
    } exp_t;

    typedef struct {
        bit          rst;
        bit          start;
        bit [CW-1:0] limit;
        bit          hold;
        bit          early;
        bit          abort;
    } stim_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    mul_step_counter #(
        .OPERAND_WIDTH(OW),
        .CNT_WIDTH    (CW)
    ) u_dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .limit     (limit),
        .hold      (hold),
        .early_stop(early_stop),
        .abort     (abort),
        .count     (count),
        .step_en   (step_en),
        .last      (last),
        .busy      (busy),
        .done      (done)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input stim_t s);
        reset      = s.rst;
        start      = s.start;
        limit      = s.limit;
        hold       = s.hold;
        early_stop = s.early;
        abort      = s.abort;
        @(posedge clk);
        #1;
    endtask

    function automatic stim_t rand_stim(input bit st);
        stim_t s;
        s.rst   = 1'b0;
        s.start = st;
        s.limit = CW'($urandom_range(2 ** CW - 1, 0));
        s.hold  = 1'($urandom_range(1, 0));
        s.early = 1'($urandom_range(1, 0));
        s.abort = 1'($urandom_range(1, 0));
        return s;
    endfunction

    // One run: plan every cycle's inputs, derive the expected outcome from
    // the step rules, queue it, then play the inputs.
    task automatic run_txn(input int lim_in, input int gap,
                           input int p_hold, input int p_early, input int p_abort);
        stim_t q[$];
        stim_t s;
        exp_t  e;
        int    lq;
        int    st;
        bit    fin;
        lq = (lim_in > OW - 1) ? OW - 1 : lim_in;
        st = 0;
        fin = 1'b0;
        e = '{done: 1'b0, busy_cycles: 0, steps: 0, lasts: 0, step_sum: 0, final_count: 0};
        s = rand_stim(1'b1);
        s.limit = CW'(lim_in);
        q.push_back(s);
        while (!fin) begin
            s = rand_stim(1'($urandom_range(1, 0)));
            s.abort = ($urandom_range(99, 0) < p_abort);
            s.hold  = (e.busy_cycles < 20) && ($urandom_range(99, 0) < p_hold);
            s.early = ($urandom_range(99, 0) < p_early);
            q.push_back(s);
            e.busy_cycles++;
            if (st == lq) e.lasts++;
            if (s.abort) begin
                fin = 1'b1;
                e.final_count = 0;
            end else if (!s.hold) begin
                e.steps++;
                e.step_sum += st;
                if (st == lq || s.early) begin
                    fin = 1'b1;
                    e.done = 1'b1;
                    e.final_count = st;
                    e.busy_cycles++;
                end else begin
                    st++;
                end
            end
        end
        if (e.done) q.push_back(rand_stim(1'($urandom_range(1, 0))));
        for (int i = 0; i < gap; i++) q.push_back(rand_stim(1'b0));
        sb.push_back(e);
        foreach (q[i]) drive(q[i]);
    endtask

    // Monitor: accumulates what the DUT shows during a busy window and
    // compares against the queued expectation when busy drops.
    initial begin
        exp_t e;
        int   nb, ns, nl, nd, sum;
        bit   pb, pd;
        nb = 0; ns = 0; nl = 0; nd = 0; sum = 0; pb = 1'b0; pd = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                nb = 0; ns = 0; nl = 0; nd = 0; sum = 0; pb = 1'b0; pd = 1'b0;
            end else begin
                if (busy) begin
                    nb++;
                    if (step_en) begin
                        ns++;
                        sum += int'(count);
                    end
                    if (last) nl++;
                    if (done) nd++;
                end else begin
                    if (step_en || last) n_stray++;
                    if (pb) begin
                        if (sb.size() == 0) begin
                            n_checks++;
                            n_errors++;
                            $display("FAIL run_end: got unexpected run end, expected none");
                        end else begin
                            e = sb.pop_front();
                            chk("busy_cycles", nb, e.busy_cycles);
                            chk("step_en_cycles", ns, e.steps);
                            chk("step_index_sum", sum, e.step_sum);
                            chk("last_cycles", nl, e.lasts);
                            chk("done_pulses", nd, int'(e.done));
                            chk("done_in_final_busy_cycle", int'(pd), int'(e.done));
                            chk("idle_count", int'(count), e.final_count);
                        end
                        nb = 0; ns = 0; nl = 0; nd = 0; sum = 0;
                    end
                end
                pb = busy;
                pd = done;
            end
        end
    end

    initial begin
        stim_t s;
        s = '{rst: 1'b1, start: 1'b1, limit: '1, hold: 1'b0, early: 1'b0, abort: 1'b0};
        drive(s);
        drive(s);
        chk("reset_count", int'(count), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_step_en", int'(step_en), 0);
        chk("reset_last", int'(last), 0);

        // Reset landing mid-run together with start and abort
        s = '{rst: 1'b0, start: 1'b1, limit: CW'(5), hold: 1'b0, early: 1'b0, abort: 1'b0};
        drive(s);
        s.start = 1'b0;
        drive(s);
        drive(s);
        chk("pre_reset_count", int'(count), 2);
        s = '{rst: 1'b1, start: 1'b1, limit: CW'(5), hold: 1'b0, early: 1'b0, abort: 1'b1};
        drive(s);
        chk("midrun_reset_count", int'(count), 0);
        chk("midrun_reset_busy", int'(busy), 0);
        chk("midrun_reset_done", int'(done), 0);
        chk("midrun_reset_step_en", int'(step_en), 0);
        s = '{rst: 1'b0, start: 1'b0, limit: '0, hold: 1'b0, early: 1'b0, abort: 1'b0};
        drive(s);

        run_txn(3, 1, 0, 0, 0);
        run_txn(7, 0, 0, 0, 0);
        run_txn(6, 0, 0, 0, 0);
        run_txn(1, 0, 0, 100, 0);
        run_txn(0, 0, 0, 0, 0);
        run_txn(4, 0, 40, 0, 0);
        run_txn(5, 0, 0, 0, 25);
        for (int i = 0; i < 80; i++) begin
            run_txn($urandom_range(2 ** CW - 1, 0), $urandom_range(2, 0),
                    30, 12, 6);
        end

        for (int i = 0; i < 4; i++) drive(s);
        chk("scoreboard_drained", sb.size(), 0);
        chk("idle_step_or_last", n_stray, 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
